// File: rtl/seq_div8.sv
// 8-bit unsigned restoring divider: one quotient bit per clock, MSB first, 8 steps per operation.
// Optional macro SEQ_DIV8_DZ_EARLY_EN: a zero divisor finishes after one RUN cycle instead of eight.
module seq_div8 (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] dividend,
   input  logic [7:0] divisor,
   output logic       busy,
   output logic       done,
   output logic [7:0] quotient,
   output logic [7:0] remainder,
   output logic       dz
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e     r_state;
   state_e     w_state_next;
   logic [7:0] r_dvd;        // dividend bits shift out, quotient bits shift in
   logic [7:0] r_dvs;
   logic [7:0] r_prem;
   logic [2:0] r_cnt;
   logic [7:0] r_quot;
   logic [7:0] r_rem;
   logic       r_dz;

   logic [8:0] w_shift;
   logic [8:0] w_trial;
   logic       w_neg;
   logic [7:0] w_prem_next;
   logic [7:0] w_quot_fin;
   logic [7:0] w_rem_fin;
   logic       w_dz;
   logic       w_early;
   logic       w_load;
   logic       w_finish;

   // Trial subtraction at 9 bits; bit 8 set means the shifted remainder was below the divisor.
   always_comb begin
      w_shift     = {r_prem, r_dvd[7]};
      w_trial     = w_shift + {1'b1, ~r_dvs} + 9'd1;
      w_neg       = w_trial[8];
      w_prem_next = w_neg ? w_shift[7:0] : w_trial[7:0];
      w_dz        = (r_dvs == 8'd0);
      w_quot_fin  = {r_dvd[6:0], ~w_neg};
      w_rem_fin   = w_prem_next;
      w_early     = 1'b0;
`ifdef SEQ_DIV8_DZ_EARLY_EN
      // Early exit happens on the first RUN edge, so r_dvd still holds the raw dividend.
      w_early = w_dz;
      if (w_dz) begin
         w_quot_fin = 8'hFF;
         w_rem_fin  = r_dvd;
      end
`endif
   end

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_finish     = 1'b0;
      case (r_state)
         StIdle: begin
            if (start) begin
               w_load       = 1'b1;
               w_state_next = StRun;
            end
         end
         StRun: begin
            if (w_early || (r_cnt == 3'd7)) begin
               w_finish     = 1'b1;
               w_state_next = StDone;
            end
         end
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dvd  <= 8'd0;
         r_dvs  <= 8'd0;
         r_prem <= 8'd0;
         r_cnt  <= 3'd0;
         r_quot <= 8'd0;
         r_rem  <= 8'd0;
         r_dz   <= 1'b0;
      end else begin
         if (w_load) begin
            r_dvd  <= dividend;
            r_dvs  <= divisor;
            r_prem <= 8'd0;
            r_cnt  <= 3'd0;
         end else if (r_state == StRun) begin
            r_dvd  <= {r_dvd[6:0], ~w_neg};
            r_prem <= w_prem_next;
            r_cnt  <= r_cnt + 3'd1;
         end
         // Visible results change only when an operation completes.
         if (w_finish) begin
            r_quot <= w_quot_fin;
            r_rem  <= w_rem_fin;
            r_dz   <= w_dz;
         end
      end
   end

   assign busy      = (r_state != StIdle);
   assign done      = (r_state == StDone);
   assign quotient  = r_quot;
   assign remainder = r_rem;
   assign dz        = r_dz;

endmodule
